// File: rtl/game_pkg.sv
// Shared game types and limits for the quiz round logic.
// Pure declarations, no latency; no flow control involved.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } round_state_t;

    localparam int TIME_MAX  = 99;
    localparam int SCORE_MAX = 999;

    function automatic logic [9:0] sat_add(input logic [9:0] a,
                                           input logic [9:0] b,
                                           input logic [9:0] lim);
        logic [10:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[9:0];
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second tick generator: counts 0..CLK_HZ-1 while en, held at 0 otherwise.
// Tick is asserted during the cycle the count sits at CLK_HZ-1.
// No backpressure; en low clears the count.
module sec_prescaler #(
    parameter int CLK_HZ = 25175000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/round_timer.sv
// Round countdown timer and score keeper; time bonus on correct answers under ROUND_TIMER_BONUS_EN.
// All outputs registered: new_round/timeout pulse one cycle after the causing event.
// No backpressure; start/answer pulses are consumed in the cycle they arrive.
module round_timer
    import game_pkg::*;
#(
    parameter int CLK_HZ     = 25175000,
    parameter int ROUND_SECS = 30,
    parameter int BONUS_SECS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       answer_valid,
    input  logic       answer_correct,
    output logic [9:0] time_left,
    output logic [9:0] score,
    output logic       new_round,
    output logic       timeout,
    output logic       running
);
`ifdef ROUND_TIMER_BONUS_EN
    localparam bit BONUS_ON = 1'b1;
`else
    localparam bit BONUS_ON = 1'b0;
`endif

    localparam logic [9:0] TL_MAX = 10'(TIME_MAX);
    localparam logic [9:0] SC_MAX = 10'(SCORE_MAX);
    localparam logic [9:0] BONUS  = 10'(BONUS_SECS);

    round_state_t state;
    logic         sec_tick;
    logic [9:0]   tl_dec;
    logic [9:0]   tl_next;

    sec_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (state == RUN),
        .tick (sec_tick)
    );

    // Tick and bonus fold into one update, so a coincident tick nets +BONUS-1.
    assign tl_dec  = time_left - {9'd0, sec_tick};
    assign tl_next = sat_add(tl_dec,
                             (BONUS_ON && answer_valid && answer_correct) ? BONUS : 10'd0,
                             TL_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            time_left <= 10'(ROUND_SECS);
            score     <= '0;
            new_round <= 1'b0;
            timeout   <= 1'b0;
            running   <= 1'b0;
        end else begin
            new_round <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                IDLE, EXPIRED: begin
                    if (start) begin
                        state     <= RUN;
                        running   <= 1'b1;
                        time_left <= 10'(ROUND_SECS);
                        score     <= '0;
                        new_round <= 1'b1;
                    end
                end
                RUN: begin
                    // Expiry wins over a same-cycle answer.
                    if (sec_tick && time_left == 10'd1) begin
                        state     <= EXPIRED;
                        running   <= 1'b0;
                        time_left <= '0;
                        timeout   <= 1'b1;
                    end else begin
                        time_left <= tl_next;
                        if (answer_valid) begin
                            new_round <= 1'b1;
                            if (answer_correct) begin
                                score <= sat_add(score, 10'd1, SC_MAX);
                            end
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_timer.sv
// Directed bench for round_timer with CLK_HZ=4, ROUND_SECS=3, BONUS_SECS=5.
// Inputs change on the falling edge; outputs are checked on the next falling edge.
module tb_round_timer;

    localparam int CLK_HZ     = 4;
    localparam int ROUND_SECS = 3;
    localparam int BONUS_SECS = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       answer_valid;
    logic       answer_correct;
    logic [9:0] time_left;
    logic [9:0] score;
    logic       new_round;
    logic       timeout;
    logic       running;

    int passed = 0;
    int total  = 0;

    round_timer #(
        .CLK_HZ     (CLK_HZ),
        .ROUND_SECS (ROUND_SECS),
        .BONUS_SECS (BONUS_SECS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .answer_valid   (answer_valid),
        .answer_correct (answer_correct),
        .time_left      (time_left),
        .score          (score),
        .new_round      (new_round),
        .timeout        (timeout),
        .running        (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_tl;
        int ph;
        int iter;
        logic tk;

        rst = 1'b1; start = 1'b0; answer_valid = 1'b0; answer_correct = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_time_left", time_left, 3);
        chk("rst_score",     score, 0);
        chk("rst_running",   running, 0);
        chk("rst_new_round", new_round, 0);
        chk("rst_timeout",   timeout, 0);
        rst = 1'b0;

        // Full countdown: ticks land on the 4th, 8th and 12th edge after start.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_running",   running, 1);
        chk("start_new_round", new_round, 1);
        chk("start_time_left", time_left, 3);
        chk("start_timeout",   timeout, 0);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk("run_no_new_round", new_round, 0);
            if (i == 4)  chk("tick1_time_left", time_left, 2);
            if (i == 8)  chk("tick2_time_left", time_left, 1);
            if (i == 11) chk("pre_expire_timeout", timeout, 0);
            if (i == 12) begin
                chk("expire_timeout",   timeout, 1);
                chk("expire_time_left", time_left, 0);
                chk("expire_running",   running, 0);
            end
        end
        @(negedge clk);
        chk("timeout_one_pulse", timeout, 0);
        chk("expired_hold_time", time_left, 0);

        // Restart from EXPIRED.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_running",   running, 1);
        chk("restart_time_left", time_left, 3);
        chk("restart_score",     score, 0);
        chk("restart_new_round", new_round, 1);

        // Correct then wrong answer.
        answer_valid = 1'b1; answer_correct = 1'b1;
        @(negedge clk);
        chk("correct_new_round", new_round, 1);
        chk("correct_score",     score, 1);
        answer_correct = 1'b0;
        @(negedge clk);
        answer_valid = 1'b0;
        chk("wrong_new_round", new_round, 1);
        chk("wrong_score",     score, 1);
`ifdef ROUND_TIMER_BONUS_EN
        exp_tl = 8;
`else
        exp_tl = 3;
`endif
        chk("answer_time_left", time_left, exp_tl);

        // Start during RUN is ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("run_start_new_round", new_round, 0);
        chk("run_start_running",   running, 1);
        chk("run_start_score",     score, 1);
        chk("run_start_time_left", time_left, exp_tl);
        @(negedge clk);
        chk("run_tick_time_left", time_left, exp_tl - 1);

        // Reset mid-RUN with time_left=2, score=4; rst beats start and answer.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        answer_valid = 1'b1; answer_correct = 1'b1;
        repeat (4) @(negedge clk);
        answer_valid = 1'b0; answer_correct = 1'b0;
        chk("pre_rst_score", score, 4);
`ifdef ROUND_TIMER_BONUS_EN
        chk("pre_rst_time_left", time_left, 22);
`else
        chk("pre_rst_time_left", time_left, 2);
`endif
        rst = 1'b1; start = 1'b1; answer_valid = 1'b1; answer_correct = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; answer_valid = 1'b0; answer_correct = 1'b0;
        chk("midrst_running",   running, 0);
        chk("midrst_time_left", time_left, 3);
        chk("midrst_score",     score, 0);
        chk("midrst_new_round", new_round, 0);
        chk("midrst_timeout",   timeout, 0);

        // Answers in IDLE are ignored.
        answer_valid = 1'b1; answer_correct = 1'b1;
        @(negedge clk);
        answer_valid = 1'b0; answer_correct = 1'b0;
        chk("idle_answer_score",     score, 0);
        chk("idle_answer_new_round", new_round, 0);
        chk("idle_answer_running",   running, 0);

        // Expiring tick coincides with a correct answer.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        answer_valid = 1'b1; answer_correct = 1'b1;
        @(negedge clk);
        answer_valid = 1'b0; answer_correct = 1'b0;
        chk("coinc_timeout",   timeout, 1);
        chk("coinc_new_round", new_round, 0);
        chk("coinc_score",     score, 0);
        chk("coinc_time_left", time_left, 0);

        // Answers in EXPIRED are ignored.
        answer_valid = 1'b1; answer_correct = 1'b1;
        @(negedge clk);
        answer_valid = 1'b0; answer_correct = 1'b0;
        chk("expired_answer_score",     score, 0);
        chk("expired_answer_new_round", new_round, 0);
        chk("expired_answer_time_left", time_left, 0);

`ifdef ROUND_TIMER_BONUS_EN
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("bonus_pre_time_left", time_left, 2);
        answer_valid = 1'b1; answer_correct = 1'b1;
        @(negedge clk);
        answer_valid = 1'b0; answer_correct = 1'b0;
        chk("bonus_time_left", time_left, 7);

        // Climb to 98..99, let ticks bring it to exactly 97, then answer.
        exp_tl = 7; ph = 1; iter = 0;
        while (exp_tl < 98 && iter < 200) begin
            answer_valid = 1'b1; answer_correct = 1'b1;
            tk = (ph == 3);
            @(negedge clk);
            exp_tl = exp_tl - int'(tk) + 5;
            if (exp_tl > 99) exp_tl = 99;
            ph = (ph + 1) % 4;
            iter++;
            chk("bonus_climb_time_left", time_left, exp_tl);
        end
        answer_valid = 1'b0; answer_correct = 1'b0;
        while (exp_tl != 97 && iter < 200) begin
            tk = (ph == 3);
            @(negedge clk);
            exp_tl = exp_tl - int'(tk);
            ph = (ph + 1) % 4;
            iter++;
        end
        chk("bonus_loop_bound", (iter < 200) ? 1 : 0, 1);
        chk("bonus_at_97", time_left, 97);
        answer_valid = 1'b1; answer_correct = 1'b1;
        @(negedge clk);
        answer_valid = 1'b0; answer_correct = 1'b0;
        chk("bonus_sat_99", time_left, 99);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/round_timer.md
ROUND_TIMER -- requirements
Module: round_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25175000, clock cycles per one-second tick.
REQ-002 SHALL have parameter ROUND_SECS, default 30, starting countdown value, range 1..99.
REQ-003 SHALL have parameter BONUS_SECS, default 5, seconds added per correct answer (ROUND_TIMER_BONUS_EN only).
REQ-004 SHALL have port clk  input  1  pixel clock (pll_clk domain), sole clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse; begins or restarts a game.
REQ-007 SHALL have port answer_valid  input  1  one-cycle pulse; player submitted an answer.
REQ-008 SHALL have port answer_correct  input  1  qualifies answer_valid; 1 = correct.
REQ-009 SHALL have port time_left  output  10  seconds remaining, binary; feeds two_digit_display value.
REQ-010 SHALL have port score  output  10  correct-answer count, binary.
REQ-011 SHALL have port new_round  output  1  one-cycle pulse; drives RNG trigger for a new equation.
REQ-012 SHALL have port timeout  output  1  one-cycle pulse when time_left reaches 0.
REQ-013 SHALL have port running  output  1  high while state is RUN.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, EXPIRED.
REQ-015 SHALL, in IDLE or EXPIRED on start=1: go to RUN, load time_left=ROUND_SECS, clear score, clear prescaler, and pulse new_round on the next cycle.
REQ-016 SHALL ignore start while in RUN.
REQ-017 SHALL, in RUN, count prescaler 0..CLK_HZ-1, wrapping to 0, and assert internal sec_tick for one cycle when the count equals CLK_HZ-1.
REQ-018 SHALL hold the prescaler at 0 outside RUN.
REQ-019 SHALL decrement time_left by 1 on each sec_tick in RUN.
REQ-020 SHALL, on a sec_tick with time_left==1, set time_left=0, go to EXPIRED, and pulse timeout on the next cycle.
REQ-021 SHALL, on answer_valid in RUN, pulse new_round on the next cycle regardless of answer_correct.
REQ-022 SHALL, on answer_valid with answer_correct=1 in RUN, increment score, saturating at 999.
REQ-023 SHALL leave score unchanged on a wrong answer.
REQ-024 SHALL ignore answer_valid in IDLE and EXPIRED.
REQ-025 SHALL, on the expiring sec_tick coinciding with answer_valid, give timeout priority: no score change and no new_round.
REQ-026 SHALL hold time_left and score in EXPIRED until the next start.
REQ-027 SHALL drive all outputs from registers, with no combinational input-to-output path.
REQ-028 SHALL never assert new_round and timeout in the same cycle.

Reset
REQ-029 SHALL, on rst=1 at a clk edge: state=IDLE, time_left=ROUND_SECS, score=0, prescaler=0, new_round=0, timeout=0, running=0.
REQ-030 SHALL give rst priority over start and answer_valid in the same cycle, including mid-RUN.

Configuration
REQ-031 SHALL, when ROUND_TIMER_BONUS_EN is defined, add BONUS_SECS to time_left on a correct answer in RUN, saturating at 99, in the same update as a coincident non-expiring sec_tick (net +BONUS_SECS-1).
REQ-032 SHALL, when ROUND_TIMER_BONUS_EN is undefined, leave time_left unaffected by answers.

Structure
REQ-033 SHALL take round_state_t (IDLE/RUN/EXPIRED enum), TIME_MAX=99 and SCORE_MAX=999 from shared package game_pkg.
REQ-034 SHALL place the one-second tick generator in sub-module sec_prescaler (parameter CLK_HZ; ports clk, rst, en, tick).

Verification (CLK_HZ=4, ROUND_SECS=3, BONUS_SECS=5)
REQ-035 SHALL cover: reset then start pulse -> running=1 next cycle, new_round one pulse, time_left=3; after 12 cycles timeout pulse, time_left=0, running=0.
REQ-036 SHALL cover: RUN, answer_valid with answer_correct=1 then =0 -> two new_round pulses; score 0->1->1.
REQ-037 SHALL cover: expiring sec_tick coincident with a correct answer -> timeout=1, new_round=0, score unchanged.
REQ-038 SHALL cover: ROUND_TIMER_BONUS_EN defined, correct answer at time_left=2 -> time_left=7; at time_left=97 -> 99 (saturated).
REQ-039 SHALL cover: rst asserted mid-RUN at time_left=2, score=4 -> next cycle IDLE, time_left=3, score=0, no pulses.
REQ-040 SHALL cover: start during RUN -> ignored; start in EXPIRED -> restart with time_left=3, score=0.
